// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: FSM state type and key codes.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    SET      = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_SET   = 4'hC;
  localparam logic [3:0] KEY_SHOW  = 4'hD;
  localparam logic [3:0] KEY_LOCK  = 4'hE;

  // Keys 0-9 are digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_shift3.sv
// Three-digit BCD entry buffer with a saturating digit count.
module digit_shift3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [3:0]  digit,
  input  logic        clr,
  output logic [11:0] value,
  output logic        full
);

  logic [1:0] cnt;

  // Shift digits in from the right; clear wins over push, oldest digit falls off.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (clr) begin
      value <= '0;
      cnt   <= '0;
    end else if (push) begin
      value <= {value[7:0], digit};
      if (cnt != 2'd3) cnt <= cnt + 2'd1;
    end
  end

  assign full = (cnt == 2'd3);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code entry, unlock/set sessions and timed lockout.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter logic [11:0] DEFAULT_PASS   = 12'h123
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] pass_in,
  output logic [11:0] pass_set,
  output logic        mode,
  output logic        L,
  output logic        show,
  output logic        alarm,
  output logic        unlock_pulse
);

  localparam int unsigned FW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned LCW = $clog2(LOCKOUT_CYCLES);
  localparam logic [FW-1:0]  FAIL_LIMIT = FW'(MAX_TRIES);
  localparam logic [LCW-1:0] LOCK_LOAD  = LCW'(LOCKOUT_CYCLES - 1);

  lock_state_t    state, state_n;
  logic [FW-1:0]  fail_cnt, fail_n, fail_inc;
  logic [LCW-1:0] lock_cnt, lock_n;
  logic [11:0]    pass_set_n;
  logic           show_n, pulse_n;
  logic           push, clr, full;

  digit_shift3 u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .digit (key_code),
    .clr   (clr),
    .value (pass_in),
    .full  (full)
  );

  assign fail_inc = fail_cnt + FW'(1);

  // Next-state and session bookkeeping; any state change also empties the buffer.
  always_comb begin
    state_n    = state;
    fail_n     = fail_cnt;
    lock_n     = lock_cnt;
    pass_set_n = pass_set;
    show_n     = show;
    pulse_n    = 1'b0;
    push       = 1'b0;
    clr        = 1'b0;
    case (state)
      LOCKED: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            push = 1'b1;
          end else if (key_code == KEY_CLEAR) begin
            clr = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            if (full && (pass_in == pass_set)) begin
              state_n = UNLOCKED;
              fail_n  = '0;
              pulse_n = 1'b1;
            end else begin
              fail_n = fail_inc;
              clr    = 1'b1;
              if (fail_inc == FAIL_LIMIT) begin
                state_n = LOCKOUT;
                lock_n  = LOCK_LOAD;
              end
            end
          end
        end
      end
      UNLOCKED: begin
        if (key_valid) begin
          if (key_code == KEY_LOCK)      state_n = LOCKED;
          else if (key_code == KEY_SET)  state_n = SET;
        end
      end
      SET: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            push = 1'b1;
          end else if (key_code == KEY_CLEAR) begin
            clr = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            if (full) begin
              pass_set_n = pass_in;
              state_n    = UNLOCKED;
            end
          end else if (key_code == KEY_SHOW) begin
            show_n = ~show;
          end else if (key_code == KEY_LOCK) begin
            state_n = LOCKED;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt == '0) begin
          state_n = LOCKED;
          fail_n  = '0;
        end else begin
          lock_n = lock_cnt - LCW'(1);
        end
      end
      default: state_n = LOCKED;
    endcase
    if (state_n != state) clr = 1'b1;
    if (state_n != SET)   show_n = 1'b0;
  end

  // State and registered outputs; mode/L/alarm are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOCKED;
      fail_cnt     <= '0;
      lock_cnt     <= '0;
      pass_set     <= DEFAULT_PASS;
      show         <= 1'b0;
      unlock_pulse <= 1'b0;
      mode         <= 1'b0;
      L            <= 1'b1;
      alarm        <= 1'b0;
    end else begin
      state        <= state_n;
      fail_cnt     <= fail_n;
      lock_cnt     <= lock_n;
      pass_set     <= pass_set_n;
      show         <= show_n;
      unlock_pulse <= pulse_n;
      mode         <= (state_n == SET);
      L            <= (state_n == LOCKED) || (state_n == LOCKOUT);
      alarm        <= (state_n == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed self-checking bench for lock_ctrl (MAX_TRIES=3, LOCKOUT_CYCLES=8).
module tb_lock_ctrl;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] pass_in;
  logic [11:0] pass_set;
  logic        mode, L, show, alarm, unlock_pulse;

  int passed = 0;
  int total  = 0;

  lock_ctrl #(
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (8),
    .DEFAULT_PASS   (12'h123)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .pass_in      (pass_in),
    .pass_set     (pass_set),
    .mode         (mode),
    .L            (L),
    .show         (show),
    .alarm        (alarm),
    .unlock_pulse (unlock_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {mode, L, show, alarm, unlock_pulse}
  localparam logic [4:0] F_LK  = 5'b01000;
  localparam logic [4:0] F_UN  = 5'b00000;
  localparam logic [4:0] F_UP  = 5'b00001;
  localparam logic [4:0] F_ST  = 5'b10000;
  localparam logic [4:0] F_STS = 5'b10100;
  localparam logic [4:0] F_ALM = 5'b01010;

  typedef struct {
    logic        r;
    logic        kv;
    logic [3:0]  k;
    logic [11:0] pi;
    logic [11:0] ps;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic kv, input logic [3:0] k,
                     input logic [11:0] pi, input logic [11:0] ps, input logic [4:0] fl);
    vec_t v;
    v.r = r; v.kv = kv; v.k = k; v.pi = pi; v.ps = ps; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic kv, input logic [3:0] k);
    rst = r; key_valid = kv; key_code = k;
    @(posedge clk);
    #1;
    rst = 1'b0; key_valid = 1'b0; key_code = 4'hF;
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b0, 1'b1, k);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] flags();
    return {mode, L, show, alarm, unlock_pulse};
  endfunction

  task automatic chk_all(input string name, input logic [11:0] pi, input logic [11:0] ps, input logic [4:0] fl);
    chk(name, {3'b0, pass_in, pass_set, flags()}, {3'b0, pi, ps, fl});
  endtask

  task automatic fail3();
    for (int i = 0; i < 3; i++) begin
      key(4'h7);
      key(4'hA);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; key_valid = 1'b0; key_code = 4'hF;

    // reset, correct unlock, ignored keys in UNLOCKED
    add(1, 0, 4'h0, 12'h000, 12'h123, F_LK);
    add(0, 1, 4'h1, 12'h001, 12'h123, F_LK);
    add(0, 1, 4'h2, 12'h012, 12'h123, F_LK);
    add(0, 1, 4'h3, 12'h123, 12'h123, F_LK);
    add(0, 1, 4'hA, 12'h000, 12'h123, F_UP);
    add(0, 0, 4'h0, 12'h000, 12'h123, F_UN);
    add(0, 1, 4'h5, 12'h000, 12'h123, F_UN);
    add(0, 1, 4'hF, 12'h000, 12'h123, F_UN);
    add(0, 1, 4'hE, 12'h000, 12'h123, F_LK);
    // short code fails, then overflow entry unlocks
    add(0, 1, 4'h4, 12'h004, 12'h123, F_LK);
    add(0, 1, 4'h5, 12'h045, 12'h123, F_LK);
    add(0, 1, 4'hA, 12'h000, 12'h123, F_LK);
    add(0, 1, 4'h9, 12'h009, 12'h123, F_LK);
    add(0, 1, 4'h1, 12'h091, 12'h123, F_LK);
    add(0, 1, 4'h2, 12'h912, 12'h123, F_LK);
    add(0, 1, 4'h3, 12'h123, 12'h123, F_LK);
    add(0, 1, 4'hA, 12'h000, 12'h123, F_UP);
    // set password 059
    add(0, 1, 4'hC, 12'h000, 12'h123, F_ST);
    add(0, 1, 4'h0, 12'h000, 12'h123, F_ST);
    add(0, 1, 4'h5, 12'h005, 12'h123, F_ST);
    add(0, 1, 4'h9, 12'h059, 12'h123, F_ST);
    add(0, 1, 4'hD, 12'h059, 12'h123, F_STS);
    add(0, 1, 4'hA, 12'h000, 12'h059, F_UN);
    add(0, 1, 4'hE, 12'h000, 12'h059, F_LK);
    add(0, 1, 4'h0, 12'h000, 12'h059, F_LK);
    add(0, 1, 4'h5, 12'h005, 12'h059, F_LK);
    add(0, 1, 4'h9, 12'h059, 12'h059, F_LK);
    add(0, 1, 4'hA, 12'h000, 12'h059, F_UP);
    add(0, 1, 4'hE, 12'h000, 12'h059, F_LK);
    add(0, 1, 4'h1, 12'h001, 12'h059, F_LK);
    add(0, 1, 4'h2, 12'h012, 12'h059, F_LK);
    add(0, 1, 4'h3, 12'h123, 12'h059, F_LK);
    add(0, 1, 4'hA, 12'h000, 12'h059, F_LK);
    // CLEAR mid-entry, then reset with a key pending
    add(0, 1, 4'h7, 12'h007, 12'h059, F_LK);
    add(0, 1, 4'hB, 12'h000, 12'h059, F_LK);
    add(1, 1, 4'h1, 12'h000, 12'h123, F_LK);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].kv, vecs[i].k);
      chk_all($sformatf("vec%0d", i), vecs[i].pi, vecs[i].ps, vecs[i].fl);
    end

    // SET corner cases: short ENTER ignored, SHOW toggles, LOCK keeps pass_set
    step(1, 0, 4'h0);
    key(4'h1); key(4'h2); key(4'h3); key(4'hA);
    key(4'hC);
    key(4'h1);
    key(4'hA);
    chk_all("set_short_enter", 12'h001, 12'h123, F_ST);
    key(4'hD); key(4'hD);
    chk_all("show_toggle_twice", 12'h001, 12'h123, F_ST);
    key(4'hD);
    chk_all("show_on", 12'h001, 12'h123, F_STS);
    key(4'hE);
    chk_all("lock_from_set", 12'h000, 12'h123, F_LK);

    // lockout duration, keys ignored during and at exit
    step(1, 0, 4'h0);
    fail3();
    chk_all("lockout_entry", 12'h000, 12'h123, F_ALM);
    n = 1;
    for (int i = 0; i < 20 && alarm; i++) begin
      key(4'h1);
      if (pass_in != 12'h000) chk("lockout_key_ignored", {20'b0, pass_in}, 32'h0);
      if (alarm) n++;
    end
    chk("lockout_cycles", n, 8);
    chk_all("lockout_exit", 12'h000, 12'h123, F_LK);
    key(4'h1); key(4'h2); key(4'h3); key(4'hA);
    chk_all("unlock_after_lockout", 12'h000, 12'h123, F_UP);

    // reset mid-lockout after pass_set had been changed
    key(4'hC); key(4'h4); key(4'h5); key(4'h6); key(4'hA);
    chk_all("set_456", 12'h000, 12'h456, F_UN);
    key(4'hE);
    fail3();
    key(4'h1);
    chk_all("mid_lockout", 12'h000, 12'h456, F_ALM);
    step(1, 1, 4'h1);
    chk_all("reset_mid_lockout", 12'h000, 12'h123, F_LK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Keypad-driven controller for the digital lock. It sits directly upstream of the three-digit display stage and produces that stage's `pass_in`, `pass_set`, `mode`, `L` and `show` inputs. It accepts one-cycle key events, assembles three-digit BCD codes, compares them against the stored password, manages unlock and password-set sessions, and enforces a timed lockout after repeated failures.

## Interface
- `MAX_TRIES`, default 3: consecutive failed ENTERs that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, default 1000: clock cycles spent in lockout (≥2).
- `DEFAULT_PASS`, default 12'h123: `pass_set` value loaded at reset; three BCD digits.
- `clk`  in  1: system clock. One clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `key_valid`  in  1: one-cycle strobe; `key_code` is sampled only when this is high.
- `key_code`  in  4: key. 0–9 are digits; A is ENTER; B is CLEAR; C is SET; D is SHOW; E is LOCK; F is ignored.
- `pass_in`  out  12: digits being entered, `{d2,d1,d0}`, most recent digit in [3:0].
- `pass_set`  out  12: stored password.
- `mode`  out  1: 1 in the SET state, otherwise 0.
- `L`  out  1: 1 when locked (LOCKED or LOCKOUT).
- `show`  out  1: display-stored-password request; only ever 1 in SET.
- `alarm`  out  1: 1 throughout LOCKOUT.
- `unlock_pulse`  out  1: one-cycle pulse on a successful unlock.

## Operation
States are LOCKED, UNLOCKED, SET and LOCKOUT. Keys not listed for a state are ignored and change nothing.

**Digit buffer**
- A digit key shifts in: `pass_in <= {pass_in[7:0], digit}`.
- `cnt` increments and saturates at 3. A 4th or later digit drops the oldest and `cnt` stays 3.
- CLEAR sets `pass_in` to 0 and `cnt` to 0.
- Every state transition also clears `pass_in` and `cnt`.

**LOCKED** (`L`=1, `mode`=0)
- Digits and CLEAR operate the buffer.
- ENTER with `cnt`==3 and `pass_in`==`pass_set`:
  - go to UNLOCKED;
  - `fail_cnt` := 0;
  - `unlock_pulse` := 1.
- Any other ENTER, including `cnt`<3, is a failure:
  - `fail_cnt` is incremented;
  - if the new value equals `MAX_TRIES`, go to LOCKOUT and load the lockout counter with `LOCKOUT_CYCLES`-1;
  - otherwise stay in LOCKED with the buffer cleared.

**UNLOCKED** (`L`=0, `mode`=0)
- LOCK goes to LOCKED.
- SET goes to SET.
- Digits are ignored.

**SET** (`L`=0, `mode`=1)
- Digits and CLEAR operate the buffer.
- ENTER with `cnt`==3: `pass_set <= pass_in`, go to UNLOCKED.
- ENTER with `cnt`<3 is ignored.
- SHOW toggles `show`.
- LOCK goes to LOCKED and leaves `pass_set` unchanged.
- Leaving SET clears `show`.

**LOCKOUT** (`L`=1, `alarm`=1)
- All keys are ignored.
- The counter decrements each cycle. At 0, go to LOCKED with `fail_cnt` := 0.

**Widths**
- `fail_cnt` is `$clog2(MAX_TRIES+1)` bits.
- The lockout counter is `$clog2(LOCKOUT_CYCLES)` bits.
- Password compare is a full 12-bit equality test.

## Timing
- All outputs are registered.
- A key sampled at edge N is reflected on the outputs after edge N; latency is 1 cycle.
- `unlock_pulse` is high for exactly the one cycle in which `L` first reads 0.
- Keys may arrive on consecutive cycles; each one is processed.
- Reset values:
  - state = LOCKED;
  - `pass_in` = 0, `cnt` = 0;
  - `pass_set` = `DEFAULT_PASS`;
  - `mode` = 0, `L` = 1, `show` = 0, `alarm` = 0, `unlock_pulse` = 0;
  - `fail_cnt` = 0, lockout counter = 0.
- Reset takes priority over `key_valid` in the same cycle.
- Reset in any state, including mid-lockout or mid-SET, returns to the reset values above. A `pass_set` written earlier is lost and reverts to `DEFAULT_PASS`.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles of `alarm`=1, measured from the cycle after the failing ENTER.
- A key arriving on the cycle LOCKOUT exits is ignored.

## Structure
- Package `lock_pkg` holds:
  - the state enum `lock_state_t` (LOCKED, UNLOCKED, SET, LOCKOUT);
  - `localparam`s for the key codes `KEY_ENTER`=4'hA, `KEY_CLEAR`=4'hB, `KEY_SET`=4'hC, `KEY_SHOW`=4'hD, `KEY_LOCK`=4'hE.
- Sub-module `digit_shift3` implements the digit buffer:
  - inputs: `clk`, `rst`, `push`, `digit[3:0]`, `clr`;
  - outputs: `value[11:0]`, `full`;
  - `full` means `cnt`==3.
- The FSM, failure counter and lockout counter live in `lock_ctrl`.

## Test plan
- **Correct unlock:** after reset, keys 1,2,3,ENTER → `L`=0, `unlock_pulse` high for 1 cycle, `pass_in`=0, `fail_cnt`=0.
- **Short code and overflow:** keys 4,5,ENTER counts as one failure, `L` stays 1. Then 9,1,2,3,ENTER → `pass_in` is 12'h123 before ENTER, and unlock succeeds.
- **Lockout:** with `MAX_TRIES`=3 and `LOCKOUT_CYCLES`=8, three wrong ENTERs (7,7,7) give `alarm`=1 for exactly 8 cycles with digit keys ignored. Afterwards `L`=1 and `alarm`=0, and 1,2,3,ENTER unlocks.
- **Set password:** from UNLOCKED, keys SET,0,5,9,SHOW → `mode`=1, `show`=1, `pass_in`=12'h059. Then ENTER → `pass_set`=12'h059, `mode`=0, `show`=0. Then LOCK,0,5,9,ENTER unlocks, and LOCK,1,2,3,ENTER fails.
- **Reset mid-lockout:** assert `rst` with `key_valid` high during LOCKOUT → next cycle all outputs at reset values and `pass_set`=12'h123.
- **Ignored keys:** CLEAR mid-entry gives `pass_in`=0. Key F and digits in UNLOCKED leave every output unchanged.
